// File: rtl/edib_clkgen_pkg.sv
// Shared definitions for the EDIB receive clock generator.
// Holds the mode encodings, the controller state enum and the
// default half-period constants (in clk_12m cycles).
package edib_clkgen_pkg;

  // Telemetry mode encodings as seen on mode_sel / cur_mode
  localparam logic [1:0] MODE_M2     = 2'd0;
  localparam logic [1:0] MODE_M5     = 2'd1;
  localparam logic [1:0] MODE_M7     = 2'd2;
  localparam logic [1:0] MODE_CUSTOM = 2'd3;

  // Default half-periods: 12 MHz / (2*half)
  localparam int unsigned DEF_HALF_M2 = 6;   // 1 MHz
  localparam int unsigned DEF_HALF_M5 = 12;  // 500 kHz
  localparam int unsigned DEF_HALF_M7 = 3;   // 2 MHz
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : edib_clkgen_pkg

// File: rtl/edib_clk_div_core.sv
// Half-period counter and toggle flop producing the divided clock.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_en              : 1 = divider running, 0 = clock held low, counter 0
//   i_load            : load i_load_half as the active half-period
//   i_load_half       : new half-period (must be >= 1)
//   o_clk             : divided clock (registered)
//   o_rise / o_fall   : 1-cycle strobes registered with o_clk
//   o_fall_next_c     : combinational, o_clk falls at the next edge
module edib_clk_div_core
  import edib_clkgen_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned RST_HALF = DEF_HALF_M2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_half,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_fall_next_c
);

  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;
  logic             w_wrap;

  // Last count of the current phase
  assign w_wrap        = (r_cnt == CNT_W'(r_half - CNT_W'(1)));
  assign o_fall_next_c = i_en && r_clk && w_wrap;

  // Counter, toggle and strobes; a load always restarts the phase count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_half <= CNT_W'(RST_HALF);
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!i_en) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_rise <= ~r_clk;
        r_fall <= r_clk;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_load) begin
        r_half <= i_load_half;
        r_cnt  <= '0;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : edib_clk_div_core

// File: rtl/edib_rcv_clk_ctrl.sv
// EDIB receive bit-clock controller: selects the half-period for the
// requested telemetry mode and sequences start/stop/mode changes so
// that every switch lands on a clk_rcv falling edge (no runt pulses).
// Ports:
//   clk_12m, reset            : 12 MHz clock, synchronous active-high reset
//   run_en                    : level, 1 = clk_rcv running
//   mode_req_valid/ready      : mode change handshake
//   mode_sel, custom_half     : requested mode and custom half-period
//   clk_rcv, rcv_rise/fall    : divided clock and its edge strobes
//   cur_mode                  : mode currently applied
//   busy                      : 1 while draining to a falling edge
// Optional (macro EDIB_RCV_CLK_CNT_EN):
//   rcv_edge_cnt              : count of rcv_rise strobes, cleared on mode load
module edib_rcv_clk_ctrl
  import edib_clkgen_pkg::*;
#(
  parameter int unsigned HALF_M2 = DEF_HALF_M2,
  parameter int unsigned HALF_M5 = DEF_HALF_M5,
  parameter int unsigned HALF_M7 = DEF_HALF_M7,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk_12m,
  input  logic             reset,
  input  logic             run_en,
  input  logic             mode_req_valid,
  output logic             mode_req_ready,
  input  logic [1:0]       mode_sel,
  input  logic [CNT_W-1:0] custom_half,
  output logic             clk_rcv,
  output logic             rcv_rise,
  output logic             rcv_fall,
  output logic [1:0]       cur_mode,
  output logic             busy
`ifdef EDIB_RCV_CLK_CNT_EN
  ,
  output logic [15:0]      rcv_edge_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready;
  logic             r_busy;
  logic [1:0]       r_cur_mode;
  logic             r_pend_valid;
  logic [1:0]       r_pend_mode;
  logic [CNT_W-1:0] r_pend_half;

  logic [CNT_W-1:0] w_req_half;
  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_load_half;
  logic [1:0]       w_load_mode;
  logic             w_pend_set;
  logic             w_pend_clr;
  logic             w_div_en;
  logic             w_fall_next;
  logic             w_rise;

  assign w_accept = mode_req_valid && r_ready;
  assign w_div_en = (r_state != STOP);

  // Half-period for the requested mode; custom 0 is clamped to 1
  always_comb begin
    w_req_half = CNT_W'(HALF_M2);
    case (mode_sel)
      MODE_M5:     w_req_half = CNT_W'(HALF_M5);
      MODE_M7:     w_req_half = CNT_W'(HALF_M7);
      MODE_CUSTOM: w_req_half = (custom_half == '0) ? CNT_W'(1) : custom_half;
      default:     w_req_half = CNT_W'(HALF_M2);
    endcase
  end

  // Next state and load/pending control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_half = r_pend_half;
    w_load_mode = r_pend_mode;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      STOP: begin
        // clock is idle, so a new mode can be applied immediately
        if (w_accept) begin
          w_load      = 1'b1;
          w_load_half = w_req_half;
          w_load_mode = mode_sel;
        end
        if (run_en) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_accept) w_pend_set = 1'b1;
        if (w_accept || !run_en) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // switch only on the falling edge; run_en decides stop vs continue
        if (w_fall_next) begin
          w_load      = r_pend_valid;
          w_pend_clr  = 1'b1;
          w_state_nxt = run_en ? RUN : STOP;
        end
      end
      default: w_state_nxt = STOP;
    endcase
  end

  // State, handshake flags, pending request and applied mode
  always_ff @(posedge clk_12m) begin
    if (reset) begin
      r_state      <= STOP;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_cur_mode   <= MODE_M2;
      r_pend_valid <= 1'b0;
      r_pend_mode  <= MODE_M2;
      r_pend_half  <= CNT_W'(HALF_M2);
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != DRAIN);
      r_busy  <= (w_state_nxt == DRAIN);
      if (w_load) r_cur_mode <= w_load_mode;
      if (w_pend_set) begin
        r_pend_valid <= 1'b1;
        r_pend_mode  <= mode_sel;
        r_pend_half  <= w_req_half;
      end else if (w_pend_clr) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  edib_clk_div_core #(
    .CNT_W    (CNT_W),
    .RST_HALF (HALF_M2)
  ) u_div (
    .clk           (clk_12m),
    .reset         (reset),
    .i_en          (w_div_en),
    .i_load        (w_load),
    .i_load_half   (w_load_half),
    .o_clk         (clk_rcv),
    .o_rise        (w_rise),
    .o_fall        (rcv_fall),
    .o_fall_next_c (w_fall_next)
  );

  assign rcv_rise       = w_rise;
  assign mode_req_ready = r_ready;
  assign busy           = r_busy;
  assign cur_mode       = r_cur_mode;

`ifdef EDIB_RCV_CLK_CNT_EN
  logic [15:0] r_edge_cnt;

  // Rising-edge counter; restarts whenever a new mode is applied
  always_ff @(posedge clk_12m) begin
    if (reset) begin
      r_edge_cnt <= '0;
    end else if (w_load) begin
      r_edge_cnt <= '0;
    end else if (w_rise) begin
      r_edge_cnt <= r_edge_cnt + 16'd1;
    end
  end

  assign rcv_edge_cnt = r_edge_cnt;
`endif

endmodule : edib_rcv_clk_ctrl

// File: tb/tb_edib_rcv_clk_ctrl.sv
// Self-checking bench for edib_rcv_clk_ctrl. Expected clk_rcv phase
// lengths are queued as stimulus is applied and compared by a monitor
// at every clk_rcv transition (-1 = phase not checked).
module tb_edib_rcv_clk_ctrl;

  localparam int unsigned HALF_M2 = 6;
  localparam int unsigned HALF_M5 = 12;
  localparam int unsigned HALF_M7 = 3;
  localparam int unsigned CNT_W   = 8;

  logic             clk_12m;
  logic             reset;
  logic             run_en;
  logic             mode_req_valid;
  logic             mode_req_ready;
  logic [1:0]       mode_sel;
  logic [CNT_W-1:0] custom_half;
  logic             clk_rcv;
  logic             rcv_rise;
  logic             rcv_fall;
  logic [1:0]       cur_mode;
  logic             busy;
`ifdef EDIB_RCV_CLK_CNT_EN
  logic [15:0]      rcv_edge_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int sb_q[$];

  edib_rcv_clk_ctrl #(
    .HALF_M2 (HALF_M2),
    .HALF_M5 (HALF_M5),
    .HALF_M7 (HALF_M7),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_12m        (clk_12m),
    .reset          (reset),
    .run_en         (run_en),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .mode_sel       (mode_sel),
    .custom_half    (custom_half),
    .clk_rcv        (clk_rcv),
    .rcv_rise       (rcv_rise),
    .rcv_fall       (rcv_fall),
    .cur_mode       (cur_mode),
    .busy           (busy)
`ifdef EDIB_RCV_CLK_CNT_EN
    ,
    .rcv_edge_cnt   (rcv_edge_cnt)
`endif
  );

  initial begin
    clk_12m = 1'b0;
    forever #5 clk_12m = ~clk_12m;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_12m);
    #1;
  endtask

  // Issue a mode request and hold it until the handshake edge
  task automatic do_req(input logic [1:0] m, input logic [CNT_W-1:0] ch);
    int n;
    n = 0;
    mode_req_valid = 1'b1;
    mode_sel       = m;
    custom_half    = ch;
    while (!mode_req_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check_val("req_timeout", 32'(n), 32'd0);
    tick();
    mode_req_valid = 1'b0;
  endtask

  // Cycles from now until clk_rcv is seen high
  task automatic rise_latency(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!clk_rcv && n < 1000);
  endtask

  task automatic wait_sb(input int budget, input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val(tag, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Monitor: strobe consistency every cycle, phase length at each transition
  initial begin : mon
    logic prev;
    logic rst_d;
    int   run;
    int   e;
    prev  = 1'b0;
    rst_d = 1'b1;
    run   = 0;
    forever begin
      @(negedge clk_12m);
      if (reset || rst_d) begin
        run = 1;
      end else begin
        check_val("rise_strobe", 32'(rcv_rise), 32'(clk_rcv & ~prev));
        check_val("fall_strobe", 32'(rcv_fall), 32'(~clk_rcv & prev));
        if (clk_rcv != prev) begin
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e >= 0) check_val("phase_len", 32'(run), 32'(e));
          end
          run = 1;
        end else begin
          run++;
        end
      end
      prev  = clk_rcv;
      rst_d = reset;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int highs;
    reset          = 1'b1;
    run_en         = 1'b0;
    mode_req_valid = 1'b0;
    mode_sel       = 2'd0;
    custom_half    = '0;
    tick();
    tick();
    check_val("rst_clk_rcv", 32'(clk_rcv), 32'd0);
    check_val("rst_rise", 32'(rcv_rise), 32'd0);
    check_val("rst_fall", 32'(rcv_fall), 32'd0);
    check_val("rst_cur_mode", 32'(cur_mode), 32'd0);
    check_val("rst_ready", 32'(mode_req_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
`ifdef EDIB_RCV_CLK_CNT_EN
    check_val("rst_edge_cnt", 32'(rcv_edge_cnt), 32'd0);
`endif
    reset = 1'b0;

    // M2 start: RUN entry one edge after run_en, first rise HALF_M2 later
    sb_q.push_back(-1);
    repeat (4) sb_q.push_back(HALF_M2);
    run_en = 1'b1;
    rise_latency(n);
    check_val("m2_first_rise", 32'(n), 32'(HALF_M2 + 1));
    check_val("m2_rise_strobe", 32'(rcv_rise), 32'd1);
    tick();
    check_val("m2_rise_width", 32'(rcv_rise), 32'd0);
    wait_sb(200, "m2_sb_timeout");

    // M2 -> M7 requested mid-high phase: switch at the falling edge
    sb_q.push_back(HALF_M2);
    repeat (4) sb_q.push_back(HALF_M7);
    do_req(2'd2, '0);
    check_val("m7_drain_ready", 32'(mode_req_ready), 32'd0);
    check_val("m7_drain_busy", 32'(busy), 32'd1);
    check_val("m7_drain_mode", 32'(cur_mode), 32'd0);
    n = 0;
    while (clk_rcv && n < 100) begin
      check_val("m7_ready_low", 32'(mode_req_ready), 32'd0);
      tick();
      n++;
    end
    check_val("m7_post_fall_strobe", 32'(rcv_fall), 32'd1);
    check_val("m7_post_ready", 32'(mode_req_ready), 32'd1);
    check_val("m7_post_busy", 32'(busy), 32'd0);
    check_val("m7_post_mode", 32'(cur_mode), 32'd2);
`ifdef EDIB_RCV_CLK_CNT_EN
    check_val("m7_edge_cnt_clr", 32'(rcv_edge_cnt), 32'd0);
`endif
    wait_sb(200, "m7_sb_timeout");

    // Custom half 0 clamps to 1 (period 2)
    sb_q.push_back(HALF_M7);
    sb_q.push_back(HALF_M7);
    repeat (4) sb_q.push_back(1);
    do_req(2'd3, 8'd0);
    wait_sb(200, "c0_sb_timeout");
    check_val("c0_mode", 32'(cur_mode), 32'd3);

    // Custom half 200 (period 400)
    repeat (4) sb_q.push_back(1);
    sb_q.push_back(200);
    sb_q.push_back(200);
    do_req(2'd3, 8'd200);
    wait_sb(1000, "c200_sb_timeout");

    // Stop while low: rest of low phase + full high phase, then STOP
    sb_q.push_back(200);
    sb_q.push_back(200);
    run_en = 1'b0;
    tick();
    check_val("stop_busy", 32'(busy), 32'd1);
    check_val("stop_ready", 32'(mode_req_ready), 32'd0);
    wait_sb(1000, "stop_sb_timeout");
    check_val("stop_clk", 32'(clk_rcv), 32'd0);
    check_val("stop_busy_drop", 32'(busy), 32'd0);
    check_val("stop_ready_back", 32'(mode_req_ready), 32'd1);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (clk_rcv) highs++;
    end
    check_val("stop_quiet", 32'(highs), 32'd0);

    // Accept and run_en in the same STOP cycle: new half from first RUN cycle
    sb_q.push_back(-1);
    sb_q.push_back(HALF_M2);
    sb_q.push_back(HALF_M2);
    run_en = 1'b1;
    do_req(2'd0, '0);
    rise_latency(n);
    check_val("stop_acc_rise", 32'(n), 32'(HALF_M2));
    check_val("stop_acc_mode", 32'(cur_mode), 32'd0);
    wait_sb(200, "stop_acc_sb_timeout");

    // M5 request together with run_en=0: one fall, STOP, mode applied
    sb_q.push_back(HALF_M2);
    run_en = 1'b0;
    do_req(2'd1, '0);
    wait_sb(200, "m5_stop_sb_timeout");
    check_val("m5_stop_mode", 32'(cur_mode), 32'd1);
    check_val("m5_stop_clk", 32'(clk_rcv), 32'd0);
    check_val("m5_stop_busy", 32'(busy), 32'd0);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (clk_rcv) highs++;
    end
    check_val("m5_stop_quiet", 32'(highs), 32'd0);
    sb_q.push_back(-1);
    repeat (4) sb_q.push_back(HALF_M5);
    run_en = 1'b1;
    rise_latency(n);
    check_val("m5_first_rise", 32'(n), 32'(HALF_M5 + 1));
    wait_sb(300, "m5_sb_timeout");

    // Reset in DRAIN with a pending M7 request
    do_req(2'd2, '0);
    check_val("rd_busy", 32'(busy), 32'd1);
    tick();
    reset  = 1'b1;
    run_en = 1'b0;
    tick();
    check_val("rd_clk", 32'(clk_rcv), 32'd0);
    check_val("rd_mode", 32'(cur_mode), 32'd0);
    check_val("rd_ready", 32'(mode_req_ready), 32'd1);
    check_val("rd_busy_clr", 32'(busy), 32'd0);
`ifdef EDIB_RCV_CLK_CNT_EN
    check_val("rd_edge_cnt", 32'(rcv_edge_cnt), 32'd0);
`endif
    reset = 1'b0;
    sb_q.push_back(-1);
    repeat (3) sb_q.push_back(HALF_M2);
    run_en = 1'b1;
    rise_latency(n);
    check_val("rd_first_rise", 32'(n), 32'(HALF_M2 + 1));
    wait_sb(200, "rd_sb_timeout");
    check_val("rd_mode_after", 32'(cur_mode), 32'd0);
`ifdef EDIB_RCV_CLK_CNT_EN
    check_val("rd_edge_cnt_2", 32'(rcv_edge_cnt), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_edib_rcv_clk_ctrl
